// File: rtl/btn_autorepeat.sv
// btn_autorepeat
// Conditions a raw mechanical push-button into a step strobe with auto-repeat.
// The raw input is synchronised (2-FF), debounced (DB_CYCLES stable cycles),
// and turned into press/release strobes. A small IDLE/DELAY/REPEAT FSM emits
// one step pulse on each accepted press, then one after HOLD_CYCLES of
// holding, then one every REP_CYCLES while the button is still held.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   btn_i         in   raw asynchronous button, active high
//   en            in   step enable; low forces the FSM to IDLE
//   btn_level     out  debounced button level
//   press_pulse   out  one-cycle strobe on accepted rising level
//   release_pulse out  one-cycle strobe on accepted falling level
//   step_pulse    out  one-cycle step strobe (initial press + auto-repeats)
//   repeat_active out  high while the FSM is in REPEAT
module btn_autorepeat #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REP_CYCLES  = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    input  logic en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse,
    output logic repeat_active
);

    // A one-cycle debounce still needs a 1-bit counter signal to exist.
    localparam int CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TMAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
    localparam int TW   = $clog2(TMAX);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;          // internal debounced level
    logic          btn_level_q;           // registered copy, also the edge reference
    logic          press_q, release_q;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          step_q, step_d;
    logic          repeat_q, repeat_d;
    logic          rise;

    // The output copy lags the internal level by one cycle, so a mismatch
    // between the two marks the cycle right after an accepted change.
    assign rise = lvl_q & ~btn_level_q;

    // ---------------- Synchroniser + debounce ----------------
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (sync2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            lvl_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            lvl_q       <= 1'b0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            lvl_q       <= lvl_d;
            btn_level_q <= lvl_q;
            press_q     <= lvl_q & ~btn_level_q;
            release_q   <= ~lvl_q & btn_level_q;
        end
    end

    // ---------------- Repeat FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            step_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
            repeat_q <= repeat_d;
        end
    end

    // ---------------- Repeat FSM: next state ----------------
    // A low internal level while DELAY/REPEAT means the button was released;
    // it is tested before timer expiry so a coincident release wins.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (rise && en) begin
                    state_d = DELAY;
                    timer_d = '0;
                end
            end
            DELAY: begin
                if (!lvl_q || !en) begin
                    state_d = IDLE;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REPEAT: begin
                if (!lvl_q || !en) begin
                    state_d = IDLE;
                end else if (timer_q == REP_LAST) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // ---------------- Repeat FSM: outputs ----------------
    always_comb begin
        step_d   = 1'b0;
        repeat_d = (state_d == REPEAT);
        case (state_q)
            IDLE:    step_d = rise && en;
            DELAY:   step_d = lvl_q && en && (timer_q == HOLD_LAST);
            REPEAT:  step_d = lvl_q && en && (timer_q == REP_LAST);
            default: step_d = 1'b0;
        endcase
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign step_pulse    = step_q;
    assign repeat_active = repeat_q;

endmodule

// File: tb/tb_btn_autorepeat.sv
module tb_btn_autorepeat;

    localparam int DB   = 4;
    localparam int H    = 10;
    localparam int R    = 3;
    localparam int MAXE = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_i = 1'b0;
    logic en = 1'b1;
    logic btn_level, press_pulse, release_pulse, step_pulse, repeat_active;

    int compared = 0;
    int mismatched = 0;

    btn_autorepeat #(
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(H),
        .REP_CYCLES (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_i        (btn_i),
        .en           (en),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .step_pulse   (step_pulse),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    // Expected {btn_level, press, release, step, repeat} after each edge.
    logic [4:0] exp_q[$];

    // ---------------- Reference model ----------------
    // Button samples are kept per edge. The debounced level flips once the
    // DB most recent samples that have reached the debouncer (2-cycle sync
    // delay) all disagree with it. A hold run is described by its start
    // edge p: steps at p, p+H, p+H+k*R until release or en drops.
    bit hist[MAXE];
    int n;
    bit li, lo, act, all_diff, nli, stp, rep, smp;
    int p, k;

    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0; li = 1'b0; lo = 1'b0; act = 1'b0; p = 0;
            exp_q.push_back(5'b0);
        end else begin
            hist[n % MAXE] = btn_i;
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++) begin
                smp = ((n - j) >= 0) ? hist[(n - j) % MAXE] : 1'b0;
                if (smp == li) all_diff = 1'b0;
            end
            nli = all_diff ? ~li : li;
            stp = 1'b0;
            rep = 1'b0;
            if (act) begin
                if (!li || !en) begin
                    act = 1'b0;
                end else begin
                    k = n - p;
                    if (k == H || (k > H && ((k - H) % R) == 0)) stp = 1'b1;
                    rep = (k >= H);
                end
            end else if (li && !lo && en) begin
                act = 1'b1;
                p = n;
                stp = 1'b1;
            end
            exp_q.push_back({li, li & ~lo, ~li & lo, stp, rep});
            lo = li;
            li = nli;
            n++;
        end
    end

    // ---------------- Monitor ----------------
    logic [4:0] e_v, g_v;
    always @(negedge clk) begin
        g_v = {btn_level, press_pulse, release_pulse, step_pulse, repeat_active};
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL sb_empty t=%0t got lvl/prs/rel/stp/rep=%b required=<entry>", $time, g_v);
        end else begin
            e_v = exp_q.pop_front();
            if (g_v !== e_v) begin
                mismatched++;
                $display("FAIL outputs t=%0t got lvl/prs/rel/stp/rep=%b required=%b", $time, g_v, e_v);
            end
        end
    end

    // ---------------- Stimulus ----------------
    // Inputs change 2 time units after a rising edge and hold for ncyc edges.
    task automatic cyc(input bit b, input bit e, input int ncyc);
        btn_i = b;
        en = e;
        repeat (ncyc) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Asynchronous mid-cycle reset: outputs must clear before any edge.
    task automatic do_reset();
        logic [4:0] got;
        #5;
        rst_n = 1'b0;
        #1;
        got = {btn_level, press_pulse, release_pulse, step_pulse, repeat_active};
        compared++;
        if (got !== 5'b0) begin
            mismatched++;
            $display("FAIL async_reset got lvl/prs/rel/stp/rep=%b required=00000", got);
        end
        @(posedge clk);
        @(posedge clk);
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        cyc(0, 1, 10);                 // idle
        cyc(1, 1, 3);  cyc(0, 1, 15);  // glitch
        cyc(1, 1, 30); cyc(0, 1, 15);  // long hold with repeats
        cyc(1, 1, 8);  cyc(0, 1, 15);  // short press, released in DELAY
        cyc(1, 1, 16); cyc(0, 1, 15);  // release coincides with repeat expiry
        cyc(1, 0, 20);                 // enable gating while held
        cyc(1, 1, 20);                 // re-enable while held: no steps
        cyc(0, 1, 15);
        cyc(1, 1, 20); cyc(0, 1, 15);  // fresh press steps again
        cyc(1, 1, 20);                 // held, then reset mid-cycle
        do_reset();
        cyc(1, 1, 25); cyc(0, 1, 15);

        for (int i = 0; i < 150; i++) begin
            cyc($urandom_range(0, 1), ($urandom_range(0, 7) != 0), $urandom_range(1, 30));
        end
        cyc(0, 1, 10);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
